// File: rtl/esp32_boot_sequencer.sv
// Owns the ESP32 EN and boot-strap pins, arbitrating between host modem-line
// auto-reset (DTR/RTS) and internal timed reset commands into run or download mode.
module esp32_boot_sequencer #(
    parameter int C_en_low_cycles        = 2500,
    parameter int C_strap_hold_cycles    = 25000,
    parameter int C_prog_release_timeout = 26,
    parameter int C_cnt_bits             = 16
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       ftdi_ndtr,
    input  logic       ftdi_nrts,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_download,
    input  logic       cmd_hold,
    output logic       esp_en,
    output logic       strap_oe,
    output logic       strap_gpio0,
    output logic       strap_gpio2,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int TO_W = C_prog_release_timeout + 1;
    localparam logic [C_cnt_bits-1:0] EN_LAST    = C_cnt_bits'(C_en_low_cycles - 1);
    localparam logic [C_cnt_bits-1:0] STRAP_LAST = C_cnt_bits'(C_strap_hold_cycles - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOST  = 2'd1,
        RST   = 2'd2,
        STRAP = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            pins_p0, pins_p1, pair_prev;
    logic                  hold_p0, hold_p1;
    logic [C_cnt_bits-1:0] cnt, cnt_nxt;
    logic [TO_W-1:0]       to_cnt;
    logic                  mode_q, mode_nxt;
    logic                  en_q, io0_q, oe_q;
    logic                  en_nxt, io0_nxt, oe_nxt;
    logic                  pair_chg, host_edge, hold_fall, cmd_take;

    // {ndtr,nrts} -> {EN,IO0}: 10 holds EN low, 01 pulls IO0 low, 11/00 release both
    function automatic logic [1:0] host_decode(input logic [1:0] pair);
        case (pair)
            2'b10:   host_decode = 2'b01;
            2'b01:   host_decode = 2'b10;
            default: host_decode = 2'b11;
        endcase
    endfunction

    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        sat_inc = v[TO_W-1] ? v : v + 1'b1;
    endfunction

    assign pair_chg  = (pins_p1 != pair_prev);
    assign host_edge = pair_chg && ((pins_p1 == 2'b10) || (pins_p1 == 2'b01));
    assign hold_fall = hold_p1 & ~hold_p0;
    assign cmd_ready = ~reset & (state == IDLE) & ~cmd_hold & ~host_edge;
    assign cmd_take  = cmd_valid & cmd_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mode_nxt  = mode_q;
        en_nxt    = 1'b1;
        io0_nxt   = 1'b1;
        oe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (host_edge) begin
                    state_nxt = HOST;
                end else if (cmd_take) begin
                    state_nxt = RST;
                    cnt_nxt   = '0;
                    mode_nxt  = cmd_download;
                end else if (hold_fall) begin
                    state_nxt = RST;
                    cnt_nxt   = '0;
                    mode_nxt  = 1'b0;
                end
            end
            HOST: begin
                if (!pair_chg && to_cnt[TO_W-1]) state_nxt = IDLE;
            end
            RST: begin
                if (host_edge) begin
                    state_nxt = HOST;
                end else if (cnt == EN_LAST) begin
                    state_nxt = STRAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STRAP: begin
                if (host_edge) begin
                    state_nxt = HOST;
                end else if (cnt == STRAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Pin values are registered from the state being entered
        case (state_nxt)
            HOST: begin
                {en_nxt, io0_nxt} = host_decode(pins_p1);
                oe_nxt            = 1'b1;
            end
            RST: begin
                en_nxt  = 1'b0;
                io0_nxt = ~mode_nxt;
                oe_nxt  = 1'b1;
            end
            STRAP: begin
                io0_nxt = ~mode_nxt;
                oe_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            pins_p0   <= 2'b11;
            pins_p1   <= 2'b11;
            pair_prev <= 2'b11;
            hold_p0   <= 1'b0;
            hold_p1   <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            to_cnt    <= '1;
            mode_q    <= 1'b0;
            en_q      <= 1'b1;
            io0_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            pins_p0   <= {ftdi_ndtr, ftdi_nrts};
            pins_p1   <= pins_p0;
            pair_prev <= pins_p1;
            hold_p0   <= cmd_hold;
            hold_p1   <= hold_p0;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            to_cnt    <= pair_chg ? '0 : sat_inc(to_cnt);
            mode_q    <= mode_nxt;
            en_q      <= en_nxt;
            io0_q     <= io0_nxt;
            oe_q      <= oe_nxt;
        end
    end

    // The hold button overrides EN regardless of state, one register late
    assign esp_en      = en_q & ~hold_p0;
    assign strap_oe    = oe_q;
    assign strap_gpio0 = io0_q;
    assign strap_gpio2 = io0_q;
    assign busy        = (state != IDLE);
    assign state_dbg   = {1'b0, state};

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Directed bench for esp32_boot_sequencer: command sequences, host auto-reset,
// host abort, hold button, command/host collision and mid-sequence reset.
module tb_esp32_boot_sequencer;

    logic       clk_25mhz = 1'b0;
    logic       reset;
    logic       ftdi_ndtr, ftdi_nrts;
    logic       cmd_valid, cmd_ready, cmd_download, cmd_hold;
    logic       esp_en, strap_oe, strap_gpio0, strap_gpio2, busy;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    esp32_boot_sequencer #(
        .C_en_low_cycles       (10),
        .C_strap_hold_cycles   (20),
        .C_prog_release_timeout(6),
        .C_cnt_bits            (16)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .reset       (reset),
        .ftdi_ndtr   (ftdi_ndtr),
        .ftdi_nrts   (ftdi_nrts),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_download(cmd_download),
        .cmd_hold    (cmd_hold),
        .esp_en      (esp_en),
        .strap_oe    (strap_oe),
        .strap_gpio0 (strap_gpio0),
        .strap_gpio2 (strap_gpio2),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25mhz);
            #2;
        end
    endtask

    task automatic expect_pins(input string tag, input logic en, input logic io0,
                               input logic oe, input logic [2:0] st);
        check({tag, "_en"},   3'(esp_en),      3'(en));
        check({tag, "_io0"},  3'(strap_gpio0), 3'(io0));
        check({tag, "_io2"},  3'(strap_gpio2), 3'(io0));
        check({tag, "_oe"},   3'(strap_oe),    3'(oe));
        check({tag, "_st"},   state_dbg,       st);
        check({tag, "_busy"}, 3'(busy),        3'(st != 3'd0));
    endtask

    // Starts on the first cycle after the sequence began (state RST)
    task automatic check_seq(input string tag, input logic io0);
        for (int i = 0; i < 10; i++) begin
            expect_pins({tag, "_rst"}, 1'b0, io0, 1'b1, 3'd2);
            step(1);
        end
        for (int i = 0; i < 20; i++) begin
            expect_pins({tag, "_strap"}, 1'b1, io0, 1'b1, 3'd3);
            step(1);
        end
        expect_pins({tag, "_done"}, 1'b1, 1'b1, 1'b0, 3'd0);
        check({tag, "_ready"}, 3'(cmd_ready), 3'd1);
    endtask

    initial begin
        reset = 1'b1;
        ftdi_ndtr = 1'b1;
        ftdi_nrts = 1'b1;
        cmd_valid = 1'b0;
        cmd_download = 1'b0;
        cmd_hold = 1'b0;

        // Reset state
        step(3);
        expect_pins("reset", 1'b1, 1'b1, 1'b0, 3'd0);
        check("reset_ready", 3'(cmd_ready), 3'd0);
        reset = 1'b0;
        step(1);
        check("post_reset_ready", 3'(cmd_ready), 3'd1);
        expect_pins("post_reset", 1'b1, 1'b1, 1'b0, 3'd0);

        // Internal command: download, then run
        cmd_valid = 1'b1;
        cmd_download = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        check_seq("dl", 1'b0);
        cmd_valid = 1'b1;
        cmd_download = 1'b0;
        step(1);
        cmd_valid = 1'b0;
        check_seq("run", 1'b1);

        // Host esptool pattern 11 -> 10 -> 01 -> 11
        ftdi_ndtr = 1'b1; ftdi_nrts = 1'b0;
        step(2);
        expect_pins("host10_early", 1'b1, 1'b1, 1'b0, 3'd0);
        step(1);
        expect_pins("host10", 1'b0, 1'b1, 1'b1, 3'd1);
        step(27);
        expect_pins("host10_mid", 1'b0, 1'b1, 1'b1, 3'd1);
        step(70);
        ftdi_ndtr = 1'b0; ftdi_nrts = 1'b1;
        step(2);
        check("host01_early_io0", 3'(strap_gpio0), 3'd1);
        step(1);
        expect_pins("host01", 1'b1, 1'b0, 1'b1, 3'd1);
        step(47);
        ftdi_ndtr = 1'b1; ftdi_nrts = 1'b1;
        step(3);
        expect_pins("host11", 1'b1, 1'b1, 1'b1, 3'd1);
        step(57);
        expect_pins("host_hold60", 1'b1, 1'b1, 1'b1, 3'd1);
        step(10);
        expect_pins("host_timeout", 1'b1, 1'b1, 1'b0, 3'd0);

        // Host edge at cycle 5 of STRAP aborts the command
        cmd_valid = 1'b1;
        cmd_download = 1'b0;
        step(1);
        cmd_valid = 1'b0;
        step(15);
        expect_pins("abort_strap5", 1'b1, 1'b1, 1'b1, 3'd3);
        ftdi_ndtr = 1'b1; ftdi_nrts = 1'b0;
        step(2);
        check("abort_sync_st", state_dbg, 3'd3);
        step(1);
        expect_pins("abort_host", 1'b0, 1'b1, 1'b1, 3'd1);
        step(20);
        expect_pins("abort_stay", 1'b0, 1'b1, 1'b1, 3'd1);
        ftdi_ndtr = 1'b1; ftdi_nrts = 1'b1;
        step(3);
        check("abort_release_en", 3'(esp_en), 3'd1);
        step(70);
        expect_pins("abort_idle", 1'b1, 1'b1, 1'b0, 3'd0);

        // Hold button: override in IDLE, then run sequence on release
        cmd_hold = 1'b1;
        #1;
        check("hold_ready", 3'(cmd_ready), 3'd0);
        step(1);
        expect_pins("hold_on", 1'b0, 1'b1, 1'b0, 3'd0);
        step(29);
        expect_pins("hold_30", 1'b0, 1'b1, 1'b0, 3'd0);
        check("hold_30_ready", 3'(cmd_ready), 3'd0);
        cmd_hold = 1'b0;
        step(2);
        check_seq("hold_rel", 1'b1);

        // Command offered in the cycle the host edge is synchronized
        ftdi_ndtr = 1'b1; ftdi_nrts = 1'b0;
        step(1);
        check("coll_ready_before", 3'(cmd_ready), 3'd1);
        step(1);
        cmd_valid = 1'b1;
        cmd_download = 1'b1;
        #1;
        check("coll_ready", 3'(cmd_ready), 3'd0);
        step(1);
        cmd_valid = 1'b0;
        expect_pins("coll_host", 1'b0, 1'b1, 1'b1, 3'd1);
        ftdi_ndtr = 1'b1; ftdi_nrts = 1'b1;
        step(75);
        check("coll_idle_st", state_dbg, 3'd0);

        // Reset pulse mid-RST
        cmd_valid = 1'b1;
        cmd_download = 1'b1;
        step(1);
        cmd_valid = 1'b0;
        step(3);
        expect_pins("mid_rst", 1'b0, 1'b0, 1'b1, 3'd2);
        reset = 1'b1;
        #1;
        check("mid_reset_ready", 3'(cmd_ready), 3'd0);
        step(1);
        expect_pins("mid_reset", 1'b1, 1'b1, 1'b0, 3'd0);
        reset = 1'b0;
        step(1);
        check("mid_reset_after_ready", 3'(cmd_ready), 3'd1);
        check("mid_reset_after_st", state_dbg, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/esp32_boot_sequencer.md
# esp32_boot_sequencer

Controller that owns the ESP32 EN and boot-strap pins (GPIO0/GPIO2 plus strap drive enable) and arbitrates them between two requesters: the host USB-serial modem lines (DTR/RTS, esptool auto-reset) and an internal command port (soft core or buttons) requesting a timed reset into flash-run or download mode. It sits between the board top level and the ESP32 pins. The top level turns `esp_en`/`strap_oe` into open-drain or tri-state drivers: GPIO12 is driven low and GPIO13/GPIO4 are driven high only while `strap_oe=1`.

## Interface
Parameters:
- `C_en_low_cycles`, 2500: EN-low pulse length for internal commands, in clocks (100 us at 25 MHz); must be ≥1.
- `C_strap_hold_cycles`, 25000: straps held after EN release, in clocks (1 ms); must be ≥1.
- `C_prog_release_timeout`, 26: host-mode inactivity timeout of 2^n clocks (2^26 / 25 MHz ≈ 2.7 s).
- `C_cnt_bits`, 16: width of the EN/strap counter; must hold both cycle parameters.

Ports:
- `clk_25mhz` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ftdi_ndtr`, `ftdi_nrts` in 1 each: asynchronous modem lines.
- `cmd_valid` in 1 / `cmd_ready` out 1: internal reset request handshake.
- `cmd_download` in 1: with command, 1 = download boot (GPIO0=0), 0 = flash run (GPIO0=1).
- `cmd_hold` in 1: level; holds ESP32 in reset (button).
- `esp_en` out 1: 1 = release EN (hi-Z), 0 = drive EN low.
- `strap_oe` out 1: 1 = drive strap pins.
- `strap_gpio0`, `strap_gpio2` out 1 each: strap values; always equal.
- `busy` out 1: state ≠ IDLE.
- `state_dbg` out 3: encoded state for LEDs.

## Operation
- `ftdi_ndtr`/`ftdi_nrts` pass through a 2-flop synchronizer; decode uses the synced pair {dtr,rts}.
- Host decode {ndtr,nrts} → (EN,IO0) is: 11→(1,1), 00→(1,1), 10→(0,1), 01→(1,0).
- State encodings: IDLE=0, HOST=1, RST=2, STRAP=3.
- IDLE: `esp_en=1`, `strap_oe=0`, gpio0=1.
  - Any change of the synced pair into 10 or 01 → HOST. This has the highest priority.
  - Else if `cmd_valid&cmd_ready` → RST, latching mode.
  - Else if a `cmd_hold` falling edge is seen → RST with mode=run.
- HOST: `esp_en`/gpio0 registered from the decode; `strap_oe=1`.
  - Timeout counter clears on every change of the synced pair.
  - When the counter MSB sets → IDLE, `strap_oe=0`.
- RST: `esp_en=0`, `strap_oe=1`, gpio0=~mode; lasts exactly `C_en_low_cycles` clocks, then → STRAP.
- STRAP: `esp_en=1`, straps still driven; lasts exactly `C_strap_hold_cycles` clocks, then → IDLE.
- Host activity (a change into 10/01) in RST or STRAP aborts to HOST. The internal command is dropped, not retried.
- `cmd_hold=1` forces `esp_en=0` in every state, overriding the state output. It does not change state or counters.
- `cmd_ready = (state==IDLE) & ~cmd_hold & ~host_edge`. A command is never accepted in the same cycle a host edge is seen.
- Counters: `C_cnt_bits` up-counter compared with parameter−1; the timeout counter is `C_prog_release_timeout+1` bits. No wrap: both hold at terminal.

## Timing
- Reset values: state IDLE, `esp_en=1`, `strap_oe=0`, gpio0/2=1, `cmd_ready=0` during reset and 1 from the first cycle after (if `cmd_hold=0`), `busy=0`, synchronizer flops=11, timeout counter saturated.
- Reset asserted mid-sequence: the next cycle is IDLE with released outputs.
- Internal command: accepted at edge N. From N+1, `esp_en=0` for exactly `C_en_low_cycles` cycles. `esp_en=1` with `strap_oe=1` for exactly `C_strap_hold_cycles` cycles. Then `strap_oe=0`, `cmd_ready=1`.
- Host path latency: a pin change reaches `esp_en`/gpio0 3 cycles later (2 sync + 1 output register).
- Hold override latency: 1 cycle; `cmd_hold` is registered and its falling edge is detected on that register.

## Test plan
Parameters for all scenarios: `C_en_low_cycles=10`, `C_strap_hold_cycles=20`, `C_prog_release_timeout=6`.
- Reset → `esp_en=1`, `strap_oe=0`, gpio0=1, `busy=0`; `cmd_ready=1` on the cycle after reset drops.
- `cmd_valid=1`, `cmd_download=1` → `esp_en=0` 10 cycles with gpio0=0, `strap_oe=1`; then `esp_en=1` 20 cycles; then `strap_oe=0`, IDLE. Repeat with `cmd_download=0` → gpio0=1 throughout.
- Host esptool pattern {ndtr,nrts}: 11→10 for 100 cycles→01 for 50→11 → `esp_en=0`/gpio0=1, then `esp_en=1`/gpio0=0 (each 3 cycles after the pin), `strap_oe=1` until 64 cycles after the last change, then IDLE.
- Host 10 edge at cycle 5 of STRAP → HOST within 3 cycles, `esp_en=0`; no return to STRAP.
- `cmd_hold` high 30 cycles in IDLE → `esp_en=0`, `cmd_ready=0`; on release, a full RST(10)/STRAP(20) sequence with gpio0=1.
- `cmd_valid` in the same cycle a host edge is synchronized → command not accepted (`cmd_ready=0`), HOST entered; `reset` pulse mid-RST → IDLE next cycle.
